sobel_ci_issuer: RTL and testbench
==================================

Name: sobel_ci_issuer

Overview:
- Initiator side of the Sobel multicycle custom-instruction interface.
- Accepts a raster pixel stream (8-bit grey) and keeps two line buffers plus a 3x3 window.
- For every fully-interior window it packs 8 neighbour pixels into dataa/datab, pulses start, waits for done, and forwards the 32-bit result downstream with a valid/ready handshake.
- Sits between the pixel source and the sobel convolution responder.

Parameters:
- IMG_WIDTH, 640, pixels per row (>=3).
- COL_W, 10, column counter width; must satisfy 2**COL_W >= IMG_WIDTH.
- TIMEOUT_CYCLES, 256, watchdog limit in WAIT; used only with SOBEL_CI_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- pix_valid  in  1  input pixel valid.
- pix_sof  in  1  start of frame, qualified by pix_valid; marks the pixel as row 0, col 0.
- pix_data  in  8  pixel.
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready.
- ci_clk_en  out  1  custom-instruction clock enable.
- ci_start  out  1  one-cycle start pulse.
- ci_dataa  out  32  packed {w10,w02,w01,w00}, w00 in [7:0].
- ci_datab  out  32  packed {w22,w21,w20,w12}, w12 in [7:0].
- ci_done  in  1  responder completion.
- ci_result  in  32  responder result, valid when ci_done=1.
- out_valid  out  1  result valid.
- out_data  out  32  result.
- out_ready  in  1  downstream accept.
- err_timeout  out  1  sticky watchdog flag; tied 0 when the feature is disabled.

Behaviour:
- Reset values:
  - state=IDLE, col=0, row=0.
  - ci_start=0, ci_clk_en=0, ci_dataa=0, ci_datab=0.
  - out_valid=0, out_data=0, err_timeout=0.
  - Line buffers and window registers are not cleared; stale contents are masked by the row/col gating.
- ci_clk_en = 1 in every cycle after reset deasserts.
- Window convention: wRC, R=row, C=col. w22 is the newest pixel; w00 is top-left. Center w11 is held but not sent.
- Pixel accept (IDLE only; pix_ready = state==IDLE), per row r:
  - wR0<=wR1, wR1<=wR2.
  - w02<=lb1[col], w12<=lb0[col], w22<=pix.
  - lb1[col]<=lb0[col], lb0[col]<=pix.
  - Line buffers are IMG_WIDTH x 8, read combinationally, written on accept.
- Counters:
  - col increments and wraps at IMG_WIDTH-1 to 0; on wrap row increments, saturating at 2.
  - pix_sof with accept: the pixel is treated as col=0, row=0. Counters become col=1, row=0. Buffers/window are updated normally.
- Issue condition: an accepted pixel with pre-increment row==2 and col>=2 moves IDLE->ISSUE. Otherwise stay in IDLE. Yields (W-2)x(H-2) results per frame.
- State machine:
  - IDLE -> ISSUE: on issue condition. ci_dataa/ci_datab are registered from the updated window in the same edge.
  - ISSUE: ci_start=1 for exactly one cycle -> WAIT. ci_done in this cycle is ignored.
  - WAIT: on ci_done, capture ci_result into out_data, set out_valid -> OUT. ci_dataa/ci_datab are held stable throughout.
  - OUT: out_valid held, out_data stable until out_ready=1; that cycle clears out_valid -> IDLE. No new pixel is accepted in the handshake cycle; the earliest next accept is the following cycle.
- Exactly one start pulse per window; never a second start before done or timeout.
- Reset in any state returns to IDLE next edge, drops ci_start/out_valid, and discards any pending result. A late ci_done after reset is ignored (state IDLE).

Optional Feature:
- Macro SOBEL_CI_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES without ci_done: out_data=32'hFFFFFFFF, out_valid=1, err_timeout<=1 (sticky until reset), -> OUT.
  - ci_done arriving in the same cycle as expiry wins: the normal result is taken and no error is flagged.
- Undefined: no counter; WAIT waits indefinitely; err_timeout constant 0.

Decomposition:
- Shared package sobel_pkg:
  - PIX_W=8.
  - State enum {IDLE, ISSUE, WAIT, OUT}.
  - Byte-lane index constants for the dataa/datab packing, shared with the responder.
- One sub-module: sobel_line_buffer (IMG_WIDTH x 8 dual-row shift memory, read-before-write at col).
- FSM, window and counters stay in the top module.

Test Plan:
- Reset mid-WAIT -> next cycle state IDLE, pix_ready=1, ci_start=0, out_valid=0, err_timeout=0; a subsequent ci_done produces no output.
- IMG_WIDTH=4, pixels 0..15 with sof on 0, responder returns dataa^datab after 3 cycles:
  - First start follows pixel 10, with ci_dataa=0x04020100 and ci_datab=0x0A090806.
  - Exactly 4 outputs for the 4x4 frame.
- Output backpressure: out_ready=0 for 10 cycles in OUT -> out_data stable, pix_ready=0, no further ci_start; release -> one transfer, pix_ready=1 next cycle.
- Done latency sweep 1, 2, 20 cycles -> exactly one ci_start per window; ci_dataa/ci_datab stable from start until done.
- pix_sof asserted at row 3 col 1, IMG_WIDTH=4 -> no start until the 11th pixel after sof (row 2, col 2 relative to new frame).
- SOBEL_CI_TIMEOUT_EN, TIMEOUT_CYCLES=16, responder never done -> out_data=0xFFFFFFFF after 16 WAIT cycles, err_timeout=1 and stays 1 through later normal windows until reset.

Source files
------------

// File: rtl/sobel_ci_issuer_pkg.sv
// sobel_pkg: definitions shared by the Sobel custom-instruction issuer and
// its responder.
//   PIX_W            grey pixel width
//   state_t          issuer handshake states
//   LANE_A_* / _B_*  byte-lane positions of the window pixels in
//                    ci_dataa / ci_datab
package sobel_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    // ci_dataa = {w10, w02, w01, w00}
    localparam int LANE_A_W00 = 0;
    localparam int LANE_A_W01 = 1;
    localparam int LANE_A_W02 = 2;
    localparam int LANE_A_W10 = 3;

    // ci_datab = {w22, w21, w20, w12}
    localparam int LANE_B_W12 = 0;
    localparam int LANE_B_W20 = 1;
    localparam int LANE_B_W21 = 2;
    localparam int LANE_B_W22 = 3;

endpackage

// File: rtl/sobel_ci_issuer_line_buffer.sv
// sobel_line_buffer: two IMG_WIDTH x PIX_W row memories forming a shift
// column.  On a write at col, the lower row moves up and the new pixel
// enters the lower row.  Both rows are read combinationally, so reads
// return the contents from before the write.
// Ports:
//   clk     rising-edge clock
//   wr_en   shift/write strobe (one accepted pixel)
//   col     column address
//   din     incoming pixel
//   lb0_rd  pixel one row above at col
//   lb1_rd  pixel two rows above at col
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH = 640,
    parameter int COL_W     = 10
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [COL_W-1:0] col,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] lb0_rd,
    output logic [PIX_W-1:0] lb1_rd
);

    logic [PIX_W-1:0] lb0 [IMG_WIDTH];
    logic [PIX_W-1:0] lb1 [IMG_WIDTH];

    assign lb0_rd = lb0[col];
    assign lb1_rd = lb1[col];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            lb1[col] <= lb0[col];
            lb0[col] <= din;
        end
    end

endmodule

// File: rtl/sobel_ci_issuer.sv
// sobel_ci_issuer: initiator side of the Sobel multicycle custom
// instruction.  It takes a raster grey pixel stream and keeps a 3x3 window
// over two line buffers.  For each fully interior window it sends eight
// neighbours on ci_dataa/ci_datab and pulses ci_start.  It then waits for
// ci_done and presents ci_result downstream with a valid/ready handshake.
// Optional feature macro: SOBEL_CI_TIMEOUT_EN.  When it is defined, a WAIT
// watchdog returns 32'hFFFFFFFF and sets the sticky err_timeout flag.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   pix_valid/sof/data    pixel stream in; pix_ready accepts it (IDLE only)
//   ci_clk_en, ci_start   custom-instruction enable and one-cycle start
//   ci_dataa, ci_datab    packed window pixels
//   ci_done, ci_result    responder completion and result
//   out_valid/data/ready  result stream out
//   err_timeout           sticky watchdog flag (0 without the feature)
module sobel_ci_issuer
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH      = 640,
    parameter int COL_W          = 10,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic [PIX_W-1:0] pix_data,
    output logic             pix_ready,
    output logic             ci_clk_en,
    output logic             ci_start,
    output logic [31:0]      ci_dataa,
    output logic [31:0]      ci_datab,
    input  logic             ci_done,
    input  logic [31:0]      ci_result,
    output logic             out_valid,
    output logic [31:0]      out_data,
    input  logic             out_ready,
    output logic             err_timeout
);

    if (IMG_WIDTH < 3 || (64'(1) << COL_W) < 64'(IMG_WIDTH) || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("sobel_ci_issuer: invalid IMG_WIDTH/COL_W/TIMEOUT_CYCLES");
    end

    state_t state, state_next;

    logic [COL_W-1:0] col, col_eff;
    logic [1:0]       row, row_eff;
    logic             accept, issue, wrap, timeout_hit;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    // Only the two right-hand window columns are stored.  The left column
    // after a shift is the old middle column, so it is read from w11/w01/w21.
    logic [PIX_W-1:0] w01, w02, w11, w12, w21, w22;
    logic [31:0]      dataa_next, datab_next;

    assign pix_ready = (state == IDLE);
    assign ci_start  = (state == ISSUE);
    assign out_valid = (state == OUT);
    assign accept    = pix_valid && pix_ready;

    // A start-of-frame pixel is handled as row 0, col 0 regardless of the counters.
    assign col_eff = pix_sof ? '0 : col;
    assign row_eff = pix_sof ? '0 : row;
    assign wrap    = (col_eff == COL_W'(IMG_WIDTH - 1));
    assign issue   = (row_eff == 2'd2) && (col_eff >= COL_W'(2));

    sobel_line_buffer #(
        .IMG_WIDTH (IMG_WIDTH),
        .COL_W     (COL_W)
    ) u_line_buffer (
        .clk    (clk),
        .wr_en  (accept),
        .col    (col_eff),
        .din    (pix_data),
        .lb0_rd (lb0_rd),
        .lb1_rd (lb1_rd)
    );

    // Pack the window as it will be after this accept.
    always_comb begin
        dataa_next = '0;
        datab_next = '0;
        dataa_next[LANE_A_W00*PIX_W +: PIX_W] = w01;
        dataa_next[LANE_A_W01*PIX_W +: PIX_W] = w02;
        dataa_next[LANE_A_W02*PIX_W +: PIX_W] = lb1_rd;
        dataa_next[LANE_A_W10*PIX_W +: PIX_W] = w11;
        datab_next[LANE_B_W12*PIX_W +: PIX_W] = lb0_rd;
        datab_next[LANE_B_W20*PIX_W +: PIX_W] = w21;
        datab_next[LANE_B_W21*PIX_W +: PIX_W] = w22;
        datab_next[LANE_B_W22*PIX_W +: PIX_W] = pix_data;
    end

`ifdef SOBEL_CI_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;
    logic          err_flag;

    // wait_cnt holds the number of WAIT cycles already spent; expiry is the
    // TIMEOUT_CYCLES-th WAIT cycle, and a simultaneous ci_done takes priority.
    assign timeout_hit = (state == WAIT) && !ci_done && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign err_timeout = err_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            err_flag <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + TW'(1);
            end
            if (timeout_hit) begin
                err_flag <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && issue) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (ci_done || timeout_hit) state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col       <= '0;
            row       <= '0;
            ci_clk_en <= 1'b0;
            ci_dataa  <= '0;
            ci_datab  <= '0;
            out_data  <= '0;
        end else begin
            ci_clk_en <= 1'b1;
            if (accept) begin
                col <= wrap ? '0 : col_eff + COL_W'(1);
                row <= (wrap && row_eff != 2'd2) ? row_eff + 2'd1 : row_eff;
                if (issue) begin
                    ci_dataa <= dataa_next;
                    ci_datab <= datab_next;
                end
            end
            if (state == WAIT) begin
                if (ci_done) begin
                    out_data <= ci_result;
                end else if (timeout_hit) begin
                    out_data <= '1;
                end
            end
        end
    end

    // Window shift; stale contents are masked by the row/col issue gating.
    always_ff @(posedge clk) begin
        if (accept) begin
            w01 <= w02;
            w02 <= lb1_rd;
            w11 <= w12;
            w12 <= lb0_rd;
            w21 <= w22;
            w22 <= pix_data;
        end
    end

endmodule

// File: tb/tb_sobel_ci_issuer.sv
// Testbench for sobel_ci_issuer (IMG_WIDTH=4, TIMEOUT_CYCLES=16).
// A reference model computes each expected window from the pixel history
// of the current frame.  A responder model returns dataa^datab after a
// programmable latency.
module tb_sobel_ci_issuer;

    localparam int W  = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic [7:0]  pix_data = '0;
    logic        pix_ready;
    logic        ci_clk_en;
    logic        ci_start;
    logic [31:0] ci_dataa;
    logic [31:0] ci_datab;
    logic        ci_done = 1'b0;
    logic [31:0] ci_result = '0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b1;
    logic        err_timeout;

    always #5 clk = ~clk;

    sobel_ci_issuer #(
        .IMG_WIDTH      (W),
        .COL_W          (2),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_valid   (pix_valid),
        .pix_sof     (pix_sof),
        .pix_data    (pix_data),
        .pix_ready   (pix_ready),
        .ci_clk_en   (ci_clk_en),
        .ci_start    (ci_start),
        .ci_dataa    (ci_dataa),
        .ci_datab    (ci_datab),
        .ci_done     (ci_done),
        .ci_result   (ci_result),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .err_timeout (err_timeout)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  hist [3][W];
    int          m_line = 0;
    int          m_col = 0;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    logic [31:0] q_res[$];

    function automatic logic [7:0] px(input int l, input int c);
        return hist[l % 3][c];
    endfunction

    task automatic model_accept(input logic [7:0] p, input logic sof);
        if (sof) begin
            m_line = 0;
            m_col  = 0;
        end
        hist[m_line % 3][m_col] = p;
        if (m_line >= 2 && m_col >= 2) begin
            q_a.push_back({px(m_line-1, m_col-2), px(m_line-2, m_col), px(m_line-2, m_col-1), px(m_line-2, m_col-2)});
            q_b.push_back({p, px(m_line, m_col-1), px(m_line, m_col-2), px(m_line-1, m_col)});
        end
        m_col++;
        if (m_col == W) begin
            m_col = 0;
            m_line++;
        end
    endtask

    // ---------------- responder + start monitor ----------------
    int          lat = 3;
    bit          never = 1'b0;
    bit          busy = 1'b0;
    bit          chk_stable = 1'b0;
    int          cnt = 0;
    int          n_start = 0;
    logic [31:0] hold_a, hold_b, ea, eb;

    always @(negedge clk) begin
        ci_done = 1'b0;
        if (reset) chk_stable = 1'b0;
        if (busy && out_valid) busy = 1'b0;
        if (busy) begin
            if (chk_stable) begin
                check("dataa_stable", ci_dataa, hold_a);
                check("datab_stable", ci_datab, hold_b);
            end
            if (!never) begin
                if (cnt <= 1) begin
                    ci_done   = 1'b1;
                    ci_result = hold_a ^ hold_b;
                    busy      = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
        if (ci_start) begin
            check("start_while_busy", 32'(busy), 0);
            n_start++;
            check("start_expected", 32'(q_a.size() != 0), 1);
            if (q_a.size() != 0) begin
                ea = q_a.pop_front();
                eb = q_b.pop_front();
                check("ci_dataa", ci_dataa, ea);
                check("ci_datab", ci_datab, eb);
                q_res.push_back(never ? 32'hFFFF_FFFF : (ea ^ eb));
            end
            hold_a     = ci_dataa;
            hold_b     = ci_datab;
            busy       = 1'b1;
            cnt        = lat;
            chk_stable = 1'b1;
        end
    end

    // ---------------- output monitor ----------------
    bit          prev_v = 1'b0;
    logic [31:0] prev_d;
    int          n_out = 0;

    always @(negedge clk) begin
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && prev_v) check("out_stable", out_data, prev_d);
            if (out_valid && out_ready) begin
                n_out++;
                check("out_expected", 32'(q_res.size() != 0), 1);
                if (q_res.size() != 0) check("out_data", out_data, q_res.pop_front());
                prev_v = 1'b0;
            end else begin
                prev_v = out_valid;
                prev_d = out_data;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    bit rnd_ready = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_pix(input logic [7:0] p, input logic sof);
        int guard = 0;
        pix_valid = 1'b1;
        pix_data  = p;
        pix_sof   = sof;
        while (!pix_ready && guard < 300) begin
            tick();
            guard++;
        end
        if (!pix_ready) begin
            check("accept_timeout", 32'(pix_ready), 1);
        end else begin
            tick();
            model_accept(p, sof);
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic send_frame(input int rows, input bit gaps);
        for (int i = 0; i < rows * W; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) tick();
            send_pix(8'($urandom), i == 0);
        end
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((q_a.size() != 0 || q_res.size() != 0 || out_valid || busy) && g < 400) begin
            tick();
            g++;
        end
        check("drain_outstanding", 32'(q_a.size() + q_res.size()), 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int s0, o0, g, exp_win, rows;
        int lats[3] = '{1, 2, 20};

        tick(); tick(); tick();
        check("rst_pix_ready", 32'(pix_ready), 1);
        check("rst_ci_start", 32'(ci_start), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", out_data, 0);
        check("rst_ci_dataa", ci_dataa, 0);
        check("rst_ci_datab", ci_datab, 0);
        check("rst_err", 32'(err_timeout), 0);
        check("rst_clk_en", 32'(ci_clk_en), 0);
        reset = 1'b0;
        tick();
        check("clk_en_after_reset", 32'(ci_clk_en), 1);

        // ramp frame 0..15
        lat = 3;
        s0 = n_start;
        o0 = n_out;
        for (int i = 0; i < 10; i++) send_pix(8'(i), i == 0);
        tick(); tick();
        check("no_start_before_px10", 32'(n_start - s0), 0);
        send_pix(8'd10, 1'b0);
        check("start_after_px10", 32'(ci_start), 1);
        check("first_dataa", ci_dataa, 32'h0402_0100);
        check("first_datab", ci_datab, 32'h0A09_0806);
        for (int i = 11; i < 16; i++) send_pix(8'(i), 1'b0);
        wait_drain();
        check("ramp_out_count", 32'(n_out - o0), 4);

        // output backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) send_pix(8'($urandom), i == 0);
        g = 0;
        while (!out_valid && g < 100) begin
            tick();
            g++;
        end
        check("bp_valid", 32'(out_valid), 1);
        s0 = n_start;
        o0 = n_out;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_data", out_data, (q_res.size() != 0) ? q_res[0] : 32'hDEAD_BEEF);
            check("bp_pix_ready", 32'(pix_ready), 0);
        end
        check("bp_no_start", 32'(n_start - s0), 0);
        out_ready = 1'b1;
        tick();
        check("bp_one_transfer", 32'(n_out - o0), 1);
        check("bp_valid_cleared", 32'(out_valid), 0);
        check("bp_pix_ready_after", 32'(pix_ready), 1);

        // done latency sweep
        for (int k = 0; k < 3; k++) begin
            lat = lats[k];
            s0 = n_start;
            o0 = n_out;
            send_frame(4, 1'b1);
            wait_drain();
            check("sweep_starts", 32'(n_start - s0), 4);
            check("sweep_outs", 32'(n_out - o0), 4);
        end

        // random frames, latency and downstream readiness
        rnd_ready = 1'b1;
        exp_win = 0;
        s0 = n_start;
        for (int k = 0; k < 6; k++) begin
            lat = $urandom_range(1, 6);
            rows = $urandom_range(2, 5);
            if (rows >= 3) exp_win += (rows - 2) * (W - 2);
            send_frame(rows, 1'b1);
        end
        wait_drain();
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        check("rand_starts", 32'(n_start - s0), 32'(exp_win));

        // start of frame at row 3 col 1
        lat = 2;
        for (int i = 0; i < 13; i++) send_pix(8'($urandom), i == 0);
        wait_drain();
        s0 = n_start;
        for (int i = 0; i < 10; i++) send_pix(8'($urandom), i == 0);
        tick(); tick();
        check("sof_no_early_start", 32'(n_start - s0), 0);
        send_pix(8'($urandom), 1'b0);
        check("sof_start_at_11th", 32'(ci_start), 1);
        for (int i = 0; i < 5; i++) send_pix(8'($urandom), 1'b0);
        wait_drain();
        check("sof_frame_starts", 32'(n_start - s0), 4);

        // reset in WAIT, then a late done
        lat = 8;
        for (int i = 0; i < 11; i++) send_pix(8'($urandom), i == 0);
        tick(); tick(); tick();
        o0 = n_out;
        reset = 1'b1;
        tick();
        check("rstw_pix_ready", 32'(pix_ready), 1);
        check("rstw_ci_start", 32'(ci_start), 0);
        check("rstw_out_valid", 32'(out_valid), 0);
        check("rstw_err", 32'(err_timeout), 0);
        reset = 1'b0;
        q_a.delete();
        q_b.delete();
        q_res.delete();
        m_line = 0;
        m_col = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("late_done_ignored", 32'(out_valid), 0);
        end
        check("no_out_after_reset", 32'(n_out - o0), 0);

`ifdef SOBEL_CI_TIMEOUT_EN
        never = 1'b1;
        for (int i = 0; i < 11; i++) send_pix(8'($urandom), i == 0);
        g = 0;
        while (!out_valid && g < 60) begin
            tick();
            g++;
        end
        check("to_cycles", 32'(g), 17);
        check("to_data", out_data, 32'hFFFF_FFFF);
        check("to_err", 32'(err_timeout), 1);
        tick();
        never = 1'b0;
        lat = 2;
        for (int i = 0; i < 5; i++) send_pix(8'($urandom), 1'b0);
        wait_drain();
        check("to_err_sticky", 32'(err_timeout), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q_a.delete();
        q_b.delete();
        q_res.delete();
        check("to_err_cleared", 32'(err_timeout), 0);
`else
        check("err_tied_low", 32'(err_timeout), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
